int_div: RTL and testbench



---
 rtl/int_div_pkg.sv | 12 +
 rtl/int_div_if.sv | 14 +
 rtl/int_div_step.sv | 29 ++
 rtl/int_div.sv | 102 ++++++++++
 tb/tb_int_div.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/int_div_pkg.sv
// Shared types and sizing for the sequential signed divider.
package int_div_pkg;

  localparam int DIV_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_t;

endpackage

// File: rtl/int_div_if.sv
// Operand/result bundle between the execute stage and the divider.
interface int_div_if import int_div_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
);
  logic                 execute;
  logic [WIDTH-1:0]     val1;
  logic [WIDTH-1:0]     val2;
  logic [2*WIDTH-1:0]   out;
  logic                 ready;
  logic                 div_zero;

  modport master (output execute, val1, val2, input out, ready, div_zero);
  modport slave  (input execute, val1, val2, output out, ready, div_zero);
endinterface

// File: rtl/int_div_step.sv
// One restoring-division iteration on unsigned magnitudes; combinational.
// No state and no backpressure: results settle within the cycle.
module int_div_step import int_div_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH-1:0] w_shift;
  logic [WIDTH:0]   w_trial;

  // Partial remainder stays below the divisor magnitude, so the shifted value fits WIDTH bits.
  assign w_shift = {i_rem[WIDTH-2:0], i_quo[WIDTH-1]};
  assign w_trial = {1'b0, w_shift} - {1'b0, i_dvs};

  always_comb begin
    o_quo = {i_quo[WIDTH-2:0], 1'b0};
    o_rem = w_shift;
    if (!w_trial[WIDTH]) begin
      o_rem    = w_trial[WIDTH-1:0];
      o_quo[0] = 1'b1;
    end
  end

endmodule

// File: rtl/int_div.sv
// Signed truncating divider, one quotient bit per clock; ready rises WIDTH+1 edges after accept (1 for divide-by-zero).
// No backpressure: execute is accepted in any state and restarts the division.
module int_div import int_div_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic      clk,
  input  logic      reset,
  int_div_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  div_state_t         r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_rem, r_quo, r_dvs;
  logic               r_qsign, r_rsign, r_zero;
  logic [2*WIDTH-1:0] r_out;
  logic               r_ready, r_div_zero;

  logic [WIDTH-1:0]   w_mag1, w_mag2, w_rem_nxt, w_quo_nxt, w_rem_fix, w_quo_fix;
  logic               w_val2_zero, w_last;

  // Unsigned negation maps -2^(WIDTH-1) onto 2^(WIDTH-1), which is the wanted magnitude.
  assign w_mag1      = bus.val1[WIDTH-1] ? -bus.val1 : bus.val1;
  assign w_mag2      = bus.val2[WIDTH-1] ? -bus.val2 : bus.val2;
  assign w_val2_zero = (bus.val2 == '0);
  assign w_last      = (r_cnt == CW'(WIDTH-1));

  assign w_quo_fix = r_zero  ? '1 : (r_qsign ? -r_quo : r_quo);
  assign w_rem_fix = r_rsign ? -r_rem : r_rem;

  int_div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_dvs (r_dvs),
    .o_rem (w_rem_nxt),
    .o_quo (w_quo_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.execute) begin
      w_state_nxt = w_val2_zero ? FIX : CALC;
    end else begin
      case (r_state)
        CALC:    if (w_last) w_state_nxt = FIX;
        FIX:     w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_dvs      <= '0;
      r_qsign    <= 1'b0;
      r_rsign    <= 1'b0;
      r_zero     <= 1'b0;
      r_out      <= '0;
      r_ready    <= 1'b0;
      r_div_zero <= 1'b0;
    end else if (bus.execute) begin
      // Divide-by-zero skips CALC; preloading |val1| lets FIX restore val1 as the remainder.
      r_rem      <= w_val2_zero ? w_mag1 : '0;
      r_quo      <= w_mag1;
      r_dvs      <= w_mag2;
      r_qsign    <= bus.val1[WIDTH-1] ^ bus.val2[WIDTH-1];
      r_rsign    <= bus.val1[WIDTH-1];
      r_zero     <= w_val2_zero;
      r_cnt      <= '0;
      r_ready    <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      case (r_state)
        CALC: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt + CW'(1);
        end
        FIX: begin
          r_out      <= {w_rem_fix, w_quo_fix};
          r_ready    <= 1'b1;
          r_div_zero <= r_zero;
        end
        default: ;
      endcase
    end
  end

  assign bus.out      = r_out;
  assign bus.ready    = r_ready;
  assign bus.div_zero = r_div_zero;

endmodule

// File: tb/tb_int_div.sv
// Directed and random checks of int_div against an arithmetic reference model.
module tb_int_div;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  int_div_if #(.WIDTH(16)) bus ();

  int_div #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference: SV integer division truncates toward zero and % follows the dividend sign.
  function automatic logic [31:0] ref_div(input int a, input int b);
    int q, r;
    if (b == 0) begin
      q = -1;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r[15:0], q[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one accepted execute; returns just after the accepting edge with execute dropped.
  task automatic start(input logic signed [15:0] a, input logic signed [15:0] b);
    @(negedge clk);
    bus.execute = 1'b1;
    bus.val1    = a;
    bus.val2    = b;
    @(posedge clk);
    #1;
    bus.execute = 1'b0;
  endtask

  // Count edges until ready; exact latency is checked, loop is bounded.
  task automatic wait_ready(input string tag, input int exp_lat);
    int  n;
    bit  seen;
    n = 0;
    seen = 1'b0;
    while (n < 40 && !seen) begin
      @(posedge clk);
      #1;
      n++;
      seen = bus.ready;
    end
    chk({tag, "_latency"}, 32'(seen ? n : 99), 32'(exp_lat));
  endtask

  task automatic run(input string tag, input logic signed [15:0] a, input logic signed [15:0] b,
                     input logic [31:0] exp_out);
    start(a, b);
    chk({tag, "_busy"}, 32'(bus.ready), 32'd0);
    wait_ready(tag, (b == 0) ? 1 : 17);
    chk({tag, "_out"}, bus.out, exp_out);
    chk({tag, "_dz"}, 32'(bus.div_zero), 32'(b == 0));
  endtask

  initial begin
    logic signed [15:0] a, b;
    int t;
    bus.execute = 1'b0;
    bus.val1    = '0;
    bus.val2    = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", bus.out, 32'd0);
    chk("rst_ready", 32'(bus.ready), 32'd0);
    chk("rst_dz", 32'(bus.div_zero), 32'd0);
    reset = 1'b0;

    run("p_div_p", 16'sd100, 16'sd7, 32'h0002000E);
    run("n_div_p", -16'sd100, 16'sd7, 32'hFFFEFFF2);
    run("p_div_n", 16'sd100, -16'sd7, 32'h0002FFF2);
    run("n_div_n", -16'sd100, -16'sd7, 32'hFFFE000E);
    run("div0", 16'sd5, 16'sd0, 32'h0005FFFF);
    run("after0", 16'sd6, 16'sd3, 32'h00000002);
    run("ovf", -16'sd32768, -16'sd1, 32'h00008000);
    run("small", 16'sd7, 16'sd100, 32'h00070000);
    run("min_by1", -16'sd32768, 16'sd1, 32'h00008000);
    run("neg_div0", -16'sd9, 16'sd0, 32'hFFF7FFFF);

    // Result must hold while idle.
    repeat (5) @(posedge clk);
    #1;
    chk("hold_ready", 32'(bus.ready), 32'd1);
    chk("hold_out", bus.out, 32'hFFF7FFFF);

    // Restart mid-division: only the second result may appear.
    start(16'sd100, 16'sd7);
    repeat (6) @(posedge clk);
    @(negedge clk);
    bus.execute = 1'b1;
    bus.val1    = 16'sd50;
    bus.val2    = 16'sd5;
    @(posedge clk);
    #1;
    bus.execute = 1'b0;
    wait_ready("restart", 17);
    chk("restart_out", bus.out, 32'h0000000A);

    // Reset in flight aborts the division.
    start(16'sd1234, 16'sd11);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort_out", bus.out, 32'd0);
    chk("abort_ready", 32'(bus.ready), 32'd0);
    repeat (20) @(posedge clk);
    #1;
    chk("abort_quiet", 32'(bus.ready), 32'd0);
    run("post_abort", 16'sd1234, 16'sd11, ref_div(1234, 11));

    // Held execute keeps restarting and never completes.
    @(negedge clk);
    bus.execute = 1'b1;
    bus.val1    = 16'sd1000;
    bus.val2    = 16'sd3;
    repeat (30) @(posedge clk);
    #1;
    chk("held_busy", 32'(bus.ready), 32'd0);
    bus.execute = 1'b0;
    wait_ready("held", 17);
    chk("held_out", bus.out, ref_div(1000, 3));

    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      if (i % 3 == 0) begin
        t = int'($urandom_range(0, 16));
        b = 16'(t - 8);
      end else begin
        b = 16'($urandom);
      end
      run("rand", a, b, ref_div(int'(a), int'(b)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
